// File: rtl/sap1_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 control sequencer.
//   - opcode_e      : defined SAP-1 opcodes (upper nibble of the IR)
//   - T*_IDX        : bit index of each T-state in the one-hot ring value
//   - CW_*          : bit positions inside the 12-bit control word
//   - NOP_CW, CW_*  : inactive word and the per-step control words
package sap1_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Control word layout {Cp,Ep,Lm_,CE_,Li_,Ei_,La_,Ea,Su,Eu,Lb_,Lo_}
  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_LM_ = 9;
  localparam int CW_CE_ = 8;
  localparam int CW_LI_ = 7;
  localparam int CW_EI_ = 6;
  localparam int CW_LA_ = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_LB_ = 1;
  localparam int CW_LO_ = 0;

  // All active-low strobes high, all active-high strobes low.
  localparam logic [11:0] NOP_CW     = 12'h3E3;

  localparam logic [11:0] CW_FETCH1  = 12'h5E3;  // Ep, Lm_
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;  // Cp
  localparam logic [11:0] CW_FETCH3  = 12'h263;  // CE_, Li_
  localparam logic [11:0] CW_MAR_IR  = 12'h1A3;  // Ei_, Lm_  (LDA/ADD/SUB T4)
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;  // CE_, La_
  localparam logic [11:0] CW_RAM_B   = 12'h2E1;  // CE_, Lb_  (ADD/SUB T5)
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;  // Eu, La_
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;  // Su, Eu, La_
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;  // Ea, Lo_

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_ring_checker.sv
// sap1_ring_checker: tracks the T-state the ring counter should present and
// raises a sticky fault the first time the observed value disagrees.
//   clk     in  : system clock (posedge)
//   clr_    in  : asynchronous active-low reset
//   t_state in  : one-hot T-state from the ring counter
//   fault   out : registered, sticky protocol violation
module sap1_ring_checker
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       clr_,
  input  logic [5:0] t_state,
  output logic       fault
);

  logic [5:0] exp_q;

  // exp_q free-runs and never resyncs to t_state, so a ring that slips
  // keeps faulting rather than being silently re-aligned.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      exp_q <= T1;
      fault <= 1'b0;
    end else begin
      exp_q <= {exp_q[4:0], exp_q[5]};
      if (t_state != exp_q) fault <= 1'b1;
    end
  end

endmodule

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: decodes ring T-state + opcode into the SAP-1
// control word, latches HLT, flags illegal opcodes, counts retirements.
//   clk          in  : system clock (posedge, same edge as ring counter)
//   clr_         in  : asynchronous active-low reset
//   t_state      in  : one-hot T-state, bit0=T1 .. bit5=T6
//   opcode       in  : upper nibble of the instruction register
//   ctrl_word    out : combinational control word
//   halt         out : registered, set after HLT's T4
//   fault        out : registered, sticky ring-protocol violation
//   illegal_op   out : registered, sticky undefined-opcode flag
//   retire_count out : registered, saturating retired-instruction count
module sap1_control_sequencer
  import sap1_pkg::*;
#(
  parameter int RETIRE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    clr_,
  input  logic [5:0]              t_state,
  input  logic [3:0]              opcode,
  output logic [11:0]             ctrl_word,
  output logic                    halt,
  output logic                    fault,
  output logic                    illegal_op,
  output logic [RETIRE_WIDTH-1:0] retire_count
);

  localparam logic [RETIRE_WIDTH-1:0] RETIRE_MAX = '1;

  sap1_ring_checker u_ring_checker (
    .clk     (clk),
    .clr_    (clr_),
    .t_state (t_state),
    .fault   (fault)
  );

  // Execute-phase word for the current opcode, indexed by T4..T6.
  function automatic logic [11:0] exec_cw(input logic [3:0] op, input int step);
    logic [11:0] cw;
    cw = NOP_CW;
    case (op)
      OP_LDA: cw = (step == T4_IDX) ? CW_MAR_IR : (step == T5_IDX) ? CW_LDA_T5 : NOP_CW;
      OP_ADD: cw = (step == T4_IDX) ? CW_MAR_IR : (step == T5_IDX) ? CW_RAM_B  : CW_ADD_T6;
      OP_SUB: cw = (step == T4_IDX) ? CW_MAR_IR : (step == T5_IDX) ? CW_RAM_B  : CW_SUB_T6;
      OP_OUT: cw = (step == T4_IDX) ? CW_OUT_T4 : NOP_CW;
      default: cw = NOP_CW;  // HLT and illegal opcodes do nothing
    endcase
    return cw;
  endfunction

  // Non-one-hot T-states fall through to the default and decode as NOP.
  always_comb begin
    ctrl_word = NOP_CW;
    case (t_state)
      T1: ctrl_word = CW_FETCH1;
      T2: ctrl_word = CW_FETCH2;
      T3: ctrl_word = CW_FETCH3;
      T4: ctrl_word = exec_cw(opcode, T4_IDX);
      T5: ctrl_word = exec_cw(opcode, T5_IDX);
      T6: ctrl_word = exec_cw(opcode, T6_IDX);
      default: ctrl_word = NOP_CW;
    endcase
    if (halt || fault) ctrl_word = NOP_CW;
  end

  // All actions use the pre-edge fault value, so a fault detected on the
  // same edge as a T4/T6 action does not suppress that action.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      halt         <= 1'b0;
      illegal_op   <= 1'b0;
      retire_count <= '0;
    end else begin
      if (t_state == T4 && opcode == OP_HLT && !fault)
        halt <= 1'b1;
      if (t_state == T4 && !is_legal_op(opcode) && !halt && !fault)
        illegal_op <= 1'b1;
      if (t_state == T6 && !halt && !fault && retire_count != RETIRE_MAX)
        retire_count <= retire_count + 1'b1;
    end
  end

endmodule
